// File: rtl/icache_fetch_port_arbiter.sv
// Round-robin arbiter sharing ICache fetch lane 0 between the pipeline fetch
// stage (port 0) and a secondary reader (port 1). A grant is held until the
// cache completes; abandoned transactions are drained; a silent cache is
// failed with an error after TIMEOUT_CYCLES busy cycles.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m0_* / m1_*               requester ports (valid/address/clean in,
//                             ready/readBus/error out, ready is one-cycle)
//   c_valid, c_address        request towards the ICache
//   c_ready, c_readBus, c_error  ICache completion
//   grant_id                  current owner (selected port while idle)
//   busy                      a transaction is outstanding (BUSY or DRAIN)
module icache_fetch_port_arbiter #(
    parameter int unsigned ADDR_W         = 40,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_clean,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_readBus,
    output logic              m0_error,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_clean,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_readBus,
    output logic              m1_error,
    output logic              c_valid,
    output logic [ADDR_W-1:0] c_address,
    input  logic              c_ready,
    input  logic [DATA_W-1:0] c_readBus,
    input  logic              c_error,
    output logic              grant_id,
    output logic              busy
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            st;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              last_q;
    logic [TMO_W-1:0]  tmo_cnt;

    logic              req0;
    logic              req1;
    logic              any_req;
    logic              sel;
    logic [ADDR_W-1:0] sel_addr;
    logic              owner_valid;
    logic              owner_clean;
    logic              abandon;
    logic              timeout_hit;

    logic              rsp_fire;
    logic              rsp_port;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    // Request selection: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        req0        = m0_valid & ~m0_clean;
        req1        = m1_valid & ~m1_clean;
        any_req     = req0 | req1;
        sel         = (req0 & req1) ? ~last_q : req1;
        sel_addr    = sel ? m1_address : m0_address;
        owner_valid = owner_q ? m1_valid : m0_valid;
        owner_clean = owner_q ? m1_clean : m0_clean;
        abandon     = owner_clean | ~owner_valid;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
    end

    // Cache request and response routing; everything is forced low during reset.
    always_comb begin
        c_valid   = 1'b0;
        c_address = '0;
        grant_id  = 1'b0;
        busy      = 1'b0;
        rsp_fire  = 1'b0;
        rsp_port  = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;

        case (st)
            ST_IDLE: begin
                grant_id = any_req ? sel : owner_q;
                if (any_req) begin
                    c_valid   = 1'b1;
                    c_address = sel_addr;
                    if (c_ready) begin
                        rsp_fire = 1'b1;
                        rsp_port = sel;
                        rsp_data = c_readBus;
                        rsp_err  = c_error;
                    end
                end
            end
            ST_BUSY: begin
                c_valid   = 1'b1;
                c_address = addr_q;
                grant_id  = owner_q;
                busy      = 1'b1;
                // An abandoning owner never sees a response, even one arriving now.
                if (!abandon) begin
                    if (c_ready) begin
                        rsp_fire = 1'b1;
                        rsp_port = owner_q;
                        rsp_data = c_readBus;
                        rsp_err  = c_error;
                    end else if (timeout_hit) begin
                        rsp_fire = 1'b1;
                        rsp_port = owner_q;
                        rsp_err  = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                c_valid   = 1'b1;
                c_address = addr_q;
                grant_id  = owner_q;
                busy      = 1'b1;
            end
            default: ;
        endcase

        if (rst) begin
            c_valid   = 1'b0;
            c_address = '0;
            grant_id  = 1'b0;
            busy      = 1'b0;
            rsp_fire  = 1'b0;
            rsp_port  = 1'b0;
            rsp_data  = '0;
            rsp_err   = 1'b0;
        end

        m0_ready   = rsp_fire & ~rsp_port;
        m0_readBus = (rsp_fire & ~rsp_port) ? rsp_data : '0;
        m0_error   = rsp_fire & ~rsp_port & rsp_err;
        m1_ready   = rsp_fire & rsp_port;
        m1_readBus = (rsp_fire & rsp_port) ? rsp_data : '0;
        m1_error   = rsp_fire & rsp_port & rsp_err;
    end

    // Arbitration state.
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= ST_IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
            last_q  <= 1'b1;
            tmo_cnt <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (any_req) begin
                        last_q <= sel;
                        if (!c_ready) begin
                            st      <= ST_BUSY;
                            owner_q <= sel;
                            addr_q  <= sel_addr;
                            tmo_cnt <= TMO_W'(1);
                        end
                    end
                end
                ST_BUSY: begin
                    if (abandon) begin
                        st <= c_ready ? ST_IDLE : ST_DRAIN;
                    end else if (c_ready) begin
                        st <= ST_IDLE;
                    end else if (timeout_hit) begin
                        st <= ST_DRAIN;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (c_ready) begin
                        st <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fetch_port_arbiter.sv
module tb_icache_fetch_port_arbiter;

    localparam int unsigned ADDR_W = 40;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              m0_valid, m0_clean, m0_ready, m0_error;
    logic [ADDR_W-1:0] m0_address;
    logic [DATA_W-1:0] m0_readBus;
    logic              m1_valid, m1_clean, m1_ready, m1_error;
    logic [ADDR_W-1:0] m1_address;
    logic [DATA_W-1:0] m1_readBus;
    logic              c_valid, c_ready, c_error;
    logic [ADDR_W-1:0] c_address;
    logic [DATA_W-1:0] c_readBus;
    logic              grant_id, busy;

    int total = 0;
    int bad   = 0;

    icache_fetch_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_address(m0_address), .m0_clean(m0_clean),
        .m0_ready(m0_ready), .m0_readBus(m0_readBus), .m0_error(m0_error),
        .m1_valid(m1_valid), .m1_address(m1_address), .m1_clean(m1_clean),
        .m1_ready(m1_ready), .m1_readBus(m1_readBus), .m1_error(m1_error),
        .c_valid(c_valid), .c_address(c_address), .c_ready(c_ready),
        .c_readBus(c_readBus), .c_error(c_error),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m0_valid = 0; m0_clean = 0; m0_address = '0;
        m1_valid = 0; m1_clean = 0; m1_address = '0;
        c_ready = 0; c_error = 0; c_readBus = '0;
    endtask

    task automatic do_reset;
        rst = 1;
        clear_inputs();
        cyc();
        cyc();
        rst = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        clear_inputs();
        m0_valid = 1; m0_address = 40'h1234; c_ready = 1; c_readBus = 32'hCAFE_F00D;
        #1;
        total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL rst_c_valid got=%0b exp=0", c_valid); end
        total++; if (m0_ready !== 1'b0 || m0_readBus !== '0) begin bad++; $display("FAIL rst_m0 got=%0b/%h exp=0/0", m0_ready, m0_readBus); end
        total++; if (busy !== 1'b0 || grant_id !== 1'b0) begin bad++; $display("FAIL rst_busy_grant got=%0b/%0b exp=0/0", busy, grant_id); end
        cyc();
        cyc();
        clear_inputs();
        rst = 0;
    endtask

    // Scenario 1: zero-wait completion.
    task automatic test_zero_wait;
        m0_valid = 1; m0_address = 40'h00_0000_1000;
        c_ready = 1; c_readBus = 32'hDEAD_BEEF;
        #1;
        total++; if (c_valid !== 1'b1 || c_address !== 40'h00_0000_1000) begin bad++; $display("FAIL zw_req got=%0b/%h exp=1/1000", c_valid, c_address); end
        total++; if (m0_ready !== 1'b1 || m0_readBus !== 32'hDEAD_BEEF || m0_error !== 1'b0) begin bad++; $display("FAIL zw_rsp got=%0b/%h/%0b exp=1/deadbeef/0", m0_ready, m0_readBus, m0_error); end
        total++; if (m1_ready !== 1'b0) begin bad++; $display("FAIL zw_m1 got=%0b exp=0", m1_ready); end
        cyc();
        clear_inputs();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zw_idle got=%0b exp=0", busy); end
    endtask

    // Scenario 2: continuous contention, cache answers on the 2nd busy cycle.
    task automatic test_round_robin;
        logic e;
        logic [ADDR_W-1:0] ea;
        m0_valid = 1; m0_address = 40'h100;
        m1_valid = 1; m1_address = 40'h200;
        for (int k = 0; k < 4; k++) begin
            e  = (k % 2) == 1;
            ea = e ? 40'h200 : 40'h100;
            c_ready = 0;
            #1;
            total++; if (grant_id !== e || c_address !== ea || busy !== 1'b0) begin bad++; $display("FAIL rr_grant%0d got=%0b/%h/%0b exp=%0b/%h/0", k, grant_id, c_address, busy, e, ea); end
            cyc();
            total++; if (busy !== 1'b1 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin bad++; $display("FAIL rr_wait%0d got=%0b/%0b/%0b exp=1/0/0", k, busy, m0_ready, m1_ready); end
            cyc();
            c_ready = 1; c_readBus = 32'hA000_0000 + DATA_W'(k);
            #1;
            total++; if ((e ? m1_ready : m0_ready) !== 1'b1 || (e ? m0_ready : m1_ready) !== 1'b0
                         || (e ? m1_readBus : m0_readBus) !== 32'hA000_0000 + DATA_W'(k)) begin
                bad++; $display("FAIL rr_done%0d got=%0b%0b exp_owner=%0b", k, m0_ready, m1_ready, e);
            end
            cyc();
        end
        clear_inputs();
    endtask

    // Scenario 3: non-owner held off until the owner completes.
    task automatic test_hold_off;
        m1_valid = 1; m1_address = 40'h300;
        #1;
        total++; if (grant_id !== 1'b1 || c_address !== 40'h300) begin bad++; $display("FAIL ho_grant got=%0b/%h exp=1/300", grant_id, c_address); end
        cyc();
        m0_valid = 1; m0_address = 40'h400;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (m0_ready !== 1'b0 || c_address !== 40'h300 || grant_id !== 1'b1) begin bad++; $display("FAIL ho_hold%0d got=%0b/%h/%0b exp=0/300/1", i, m0_ready, c_address, grant_id); end
            cyc();
        end
        c_ready = 1; c_readBus = 32'h1111_1111;
        #1;
        total++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || m1_readBus !== 32'h1111_1111) begin bad++; $display("FAIL ho_m1done got=%0b/%0b/%h exp=1/0/11111111", m1_ready, m0_ready, m1_readBus); end
        cyc();
        m1_valid = 0; c_readBus = 32'h2222_2222;
        #1;
        total++; if (grant_id !== 1'b0 || c_address !== 40'h400 || busy !== 1'b0) begin bad++; $display("FAIL ho_m0grant got=%0b/%h/%0b exp=0/400/0", grant_id, c_address, busy); end
        total++; if (m0_ready !== 1'b1 || m0_readBus !== 32'h2222_2222) begin bad++; $display("FAIL ho_m0done got=%0b/%h exp=1/22222222", m0_ready, m0_readBus); end
        cyc();
        clear_inputs();
    endtask

    // Scenario 4: owner abandons, transaction drained before m1 is served.
    task automatic test_drain;
        m0_valid = 1; m0_address = 40'h500;
        #1;
        total++; if (grant_id !== 1'b0 || c_address !== 40'h500) begin bad++; $display("FAIL dr_grant got=%0b/%h exp=0/500", grant_id, c_address); end
        cyc();
        m1_valid = 1; m1_address = 40'h600;
        #1;
        total++; if (grant_id !== 1'b0 || c_address !== 40'h500) begin bad++; $display("FAIL dr_busy got=%0b/%h exp=0/500", grant_id, c_address); end
        cyc();
        m0_clean = 1;
        #1;
        total++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin bad++; $display("FAIL dr_clean got=%0b/%0b exp=0/0", m0_ready, m1_ready); end
        cyc();
        m0_clean = 0; m0_valid = 0;
        for (int i = 3; i < 6; i++) begin
            c_ready = (i == 5); c_readBus = 32'hBAD0_BAD0;
            #1;
            total++; if (c_valid !== 1'b1 || c_address !== 40'h500 || busy !== 1'b1 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
                bad++; $display("FAIL dr_cyc%0d got=%0b/%h/%0b/%0b/%0b exp=1/500/1/0/0", i, c_valid, c_address, busy, m0_ready, m1_ready);
            end
            cyc();
        end
        c_ready = 1; c_readBus = 32'h3333_3333;
        #1;
        total++; if (grant_id !== 1'b1 || c_address !== 40'h600 || m1_ready !== 1'b1 || m1_readBus !== 32'h3333_3333) begin
            bad++; $display("FAIL dr_m1 got=%0b/%h/%0b/%h exp=1/600/1/33333333", grant_id, c_address, m1_ready, m1_readBus);
        end
        cyc();
        clear_inputs();
    endtask

    // Scenario 5: timeout after 4 busy cycles, then drain.
    task automatic test_timeout;
        m0_valid = 1; m0_address = 40'h700; c_readBus = 32'h5555_5555;
        cyc();
        for (int i = 1; i <= 4; i++) begin
            #1;
            if (i < 4) begin
                total++; if (m0_ready !== 1'b0) begin bad++; $display("FAIL to_early%0d got=%0b exp=0", i, m0_ready); end
            end else begin
                total++; if (m0_ready !== 1'b1 || m0_error !== 1'b1 || m0_readBus !== '0) begin
                    bad++; $display("FAIL to_fire got=%0b/%0b/%h exp=1/1/0", m0_ready, m0_error, m0_readBus);
                end
            end
            cyc();
        end
        m0_valid = 0;
        #1;
        total++; if (busy !== 1'b1 || c_valid !== 1'b1 || c_address !== 40'h700 || m0_ready !== 1'b0) begin
            bad++; $display("FAIL to_drain got=%0b/%0b/%h/%0b exp=1/1/700/0", busy, c_valid, c_address, m0_ready);
        end
        cyc();
        c_ready = 1;
        #1;
        total++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin bad++; $display("FAIL to_discard got=%0b/%0b exp=0/0", m0_ready, m1_ready); end
        cyc();
        c_ready = 0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%0b exp=0", busy); end
    endtask

    // Scenario 6: reset during BUSY, late cache response ignored.
    task automatic test_reset_mid;
        m0_valid = 1; m0_address = 40'h800;
        cyc();
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rm_busy got=%0b exp=1", busy); end
        rst = 1;
        #1;
        total++; if (busy !== 1'b0 || c_valid !== 1'b0) begin bad++; $display("FAIL rm_rst got=%0b/%0b exp=0/0", busy, c_valid); end
        cyc();
        rst = 0; m0_valid = 0; c_ready = 1; c_readBus = 32'h7777_7777;
        #1;
        total++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || busy !== 1'b0 || c_valid !== 1'b0) begin
            bad++; $display("FAIL rm_late got=%0b/%0b/%0b/%0b exp=0/0/0/0", m0_ready, m1_ready, busy, c_valid);
        end
        cyc();
        c_ready = 0;
        m0_valid = 1; m0_address = 40'h900;
        m1_valid = 1; m1_address = 40'hA00;
        #1;
        total++; if (grant_id !== 1'b0 || c_address !== 40'h900) begin bad++; $display("FAIL rm_rearb got=%0b/%h exp=0/900", grant_id, c_address); end
        cyc();
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_zero_wait();
        do_reset();
        test_round_robin();
        test_hold_off();
        test_drain();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
